// File: rtl/oto_pilot_pkg.sv
// -----------------------------------------------------------------------------
// oto_pilot_pkg
// Shared constants for oto_pilot and its input-conditioning stage.
//   OTO_IN_WIDTH / OTO_IN_LSB : raw pad slice io_in[31:13] feeding oto_pilot
//   OTO_OUT_WIDTH             : width of oto_pilot's output group
//   DEF_*                     : default conditioning parameters
//   deb_cnt_width()           : width of a debounce counter able to hold
//                               0..DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
package oto_pilot_pkg;

    localparam int OTO_IN_WIDTH  = 19;
    localparam int OTO_IN_LSB    = 13;
    localparam int OTO_OUT_WIDTH = 3;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_SAMPLE_DIV      = 4;

    localparam int GLITCH_CNT_WIDTH = 16;

    function automatic int deb_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/oto_debounce_bit.sv
// -----------------------------------------------------------------------------
// oto_debounce_bit
// One conditioned input: synchroniser chain, debounce counter, clean flop.
//   clock, reset : system clock, synchronous active-high reset
//   raw          : asynchronous pad input
//   enable, tick : debounce evaluation happens only when both are high
//   sync_q       : synchronised raw level (last sync stage)
//   clean        : debounced level
//   accept       : this edge loads sync_q into clean (combinational, registered
//                  by the parent)
//   glitch       : this edge discards a nonzero pending count
// -----------------------------------------------------------------------------
module oto_debounce_bit
    import oto_pilot_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic enable,
    input  logic tick,
    output logic sync_q,
    output logic clean,
    output logic accept,
    output logic glitch
);

    localparam int             CW       = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt;
    logic                   eval;
    logic                   differ;

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign eval   = enable & tick;
    assign differ = sync_q ^ clean;

    // cnt == CNT_LAST is the "cnt+1 reaches DEBOUNCE_CYCLES" condition.
    assign accept = eval & differ & (cnt == CNT_LAST);
    assign glitch = eval & ~differ & (cnt != '0);

    // The chain keeps sampling while disabled so that re-enable sees a
    // settled level immediately.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, making the shift order irrelevant.
        if (reset) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clean <= RESET_VAL;
            cnt   <= '0;
        end else if (!enable) begin
            cnt   <= '0;
        end else if (tick) begin
            if (accept) begin
                clean <= sync_q;
                cnt   <= '0;
            end else if (differ) begin
                cnt   <= cnt + 1'b1;
            end else begin
                cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/oto_pilot_in_cond.sv
// -----------------------------------------------------------------------------
// oto_pilot_in_cond
// Input-conditioning stage between the pads (io_in[31:13]) and oto_pilot.
//   clock, reset  : system clock, synchronous active-high reset
//   raw_in        : asynchronous pad inputs
//   enable        : conditioning enable; low clears pending debounce counts
//   clean_out     : debounced vector for oto_pilot.io_in
//   changed_o     : one-cycle pulse when any clean_out bit updates
//   changed_mask  : bits of clean_out that updated on the last edge
//   glitch_cnt    : saturating count of edges with >=1 rejected transition
//   stable_o      : synchronised input equals clean_out on every bit
// -----------------------------------------------------------------------------
module oto_pilot_in_cond
    import oto_pilot_pkg::*;
#(
    parameter int               WIDTH           = OTO_IN_WIDTH,
    parameter int               SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            raw_in,
    input  logic                        enable,
    output logic [WIDTH-1:0]            clean_out,
    output logic                        changed_o,
    output logic [WIDTH-1:0]            changed_mask,
    output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt,
    output logic                        stable_o
);

    // A one-bit prescaler is kept for SAMPLE_DIV=1; it never leaves 0, so
    // tick is permanently high.
    localparam int                        PW          = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0]             PRE_LAST    = PW'(SAMPLE_DIV - 1);
    localparam logic [GLITCH_CNT_WIDTH-1:0] GLITCH_MAX = '1;

    logic [PW-1:0]    prescale;
    logic             tick;
    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] accept_vec;
    logic [WIDTH-1:0] glitch_vec;

    assign tick = (prescale == PRE_LAST);

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        oto_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clock  (clock),
            .reset  (reset),
            .raw    (raw_in[i]),
            .enable (enable),
            .tick   (tick),
            .sync_q (sync_vec[i]),
            .clean  (clean_out[i]),
            .accept (accept_vec[i]),
            .glitch (glitch_vec[i])
        );
    end

    // accept_vec is already gated by enable, so the mask clears itself while
    // disabled and no pulse is ever produced by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            changed_mask <= '0;
            changed_o    <= 1'b0;
            glitch_cnt   <= '0;
        end else begin
            changed_mask <= accept_vec;
            changed_o    <= |accept_vec;
            if ((|glitch_vec) && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end

    // Both operands are flop outputs; raw_in reaches stable_o only through
    // the synchroniser.
    assign stable_o = (sync_vec == clean_out);

endmodule

// File: tb/tb_oto_pilot_in_cond.sv
module tb_oto_pilot_in_cond;

    localparam int W = 19;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // dut_a: SAMPLE_DIV=1, DEBOUNCE_CYCLES=4
    logic          reset_a, en_a;
    logic [W-1:0]  raw_a, clean_a, mask_a;
    logic          chg_a, stable_a;
    logic [15:0]   gcnt_a;

    // dut_b: SAMPLE_DIV=4, DEBOUNCE_CYCLES=2
    logic          reset_b, en_b;
    logic [W-1:0]  raw_b, clean_b, mask_b;
    logic          chg_b, stable_b;
    logic [15:0]   gcnt_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    oto_pilot_in_cond #(
        .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .SAMPLE_DIV(1), .RESET_VAL('0)
    ) dut_a (
        .clock(clock), .reset(reset_a), .raw_in(raw_a), .enable(en_a),
        .clean_out(clean_a), .changed_o(chg_a), .changed_mask(mask_a),
        .glitch_cnt(gcnt_a), .stable_o(stable_a)
    );

    oto_pilot_in_cond #(
        .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .SAMPLE_DIV(4), .RESET_VAL('0)
    ) dut_b (
        .clock(clock), .reset(reset_b), .raw_in(raw_b), .enable(en_b),
        .clean_out(clean_b), .changed_o(chg_b), .changed_mask(mask_b),
        .glitch_cnt(gcnt_b), .stable_o(stable_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_clean, exp_mask;
        logic         exp_chg;
        reset_a = 1'b1; en_a = 1'b1; raw_a = '1;
        step(3);
        vec_cnt++;
        if (clean_a !== 19'h0 || chg_a !== 1'b0 || mask_a !== 19'h0 || gcnt_a !== 16'h0) begin
            err_cnt++;
            $display("FAIL reset_state: clean=%h chg=%b mask=%h gcnt=%h, expected all zero",
                     clean_a, chg_a, mask_a, gcnt_a);
        end
        vec_cnt++;
        if (stable_a !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_stable: got %b expected 1", stable_a);
        end
        reset_a = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            exp_clean = (e >= 6) ? 19'h7FFFF : 19'h0;
            exp_chg   = (e == 6);
            exp_mask  = exp_chg ? 19'h7FFFF : 19'h0;
            vec_cnt++;
            if (clean_a !== exp_clean || chg_a !== exp_chg || mask_a !== exp_mask) begin
                err_cnt++;
                $display("FAIL reset_release edge %0d: clean=%h chg=%b mask=%h, expected clean=%h chg=%b mask=%h",
                         e, clean_a, chg_a, mask_a, exp_clean, exp_chg, exp_mask);
            end
        end
    endtask

    task automatic test_clean_edge();
        logic [W-1:0] exp_clean, exp_mask;
        logic         exp_chg, exp_stable;
        reset_a = 1'b1; raw_a = '0;
        step(2);
        reset_a = 1'b0;
        step(4);
        raw_a = 19'h00020;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            exp_clean  = (e >= 6) ? 19'h00020 : 19'h0;
            exp_chg    = (e == 6);
            exp_mask   = exp_chg ? 19'h00020 : 19'h0;
            exp_stable = !(e >= 2 && e <= 5);
            vec_cnt++;
            if (clean_a !== exp_clean || chg_a !== exp_chg || mask_a !== exp_mask ||
                stable_a !== exp_stable || gcnt_a !== 16'h0) begin
                err_cnt++;
                $display("FAIL clean_edge edge %0d: clean=%h chg=%b mask=%h stable=%b gcnt=%h, expected clean=%h chg=%b mask=%h stable=%b gcnt=0",
                         e, clean_a, chg_a, mask_a, stable_a, gcnt_a,
                         exp_clean, exp_chg, exp_mask, exp_stable);
            end
        end
    endtask

    // Three-cycle pulses: the count reaches 3 of 4 and is discarded on the
    // 6th edge after the pulse starts.
    task automatic test_glitch();
        logic [W-1:0] pat;
        logic [15:0]  exp_g;
        for (int k = 0; k < 3; k++) begin
            pat   = (k == 2) ? 19'h00081 : 19'h00001;
            raw_a = 19'h00020 | pat;
            step(3);
            raw_a = 19'h00020;
            for (int e = 4; e <= 9; e++) begin
                step(1);
                exp_g = (e >= 6) ? 16'(k + 1) : 16'(k);
                vec_cnt++;
                if (gcnt_a !== exp_g || clean_a !== 19'h00020 || chg_a !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL glitch%0d edge %0d: gcnt=%h clean=%h chg=%b, expected gcnt=%h clean=00020 chg=0",
                             k, e, gcnt_a, clean_a, chg_a, exp_g);
                end
            end
        end
    endtask

    task automatic test_enable_mid();
        logic [W-1:0] exp_clean, exp_mask;
        logic         exp_chg;
        raw_a = 19'h00420;
        step(5);
        en_a = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step(1);
            vec_cnt++;
            if (clean_a !== 19'h00020 || chg_a !== 1'b0 || gcnt_a !== 16'd3 || stable_a !== 1'b0) begin
                err_cnt++;
                $display("FAIL disabled edge %0d: clean=%h chg=%b gcnt=%h stable=%b, expected clean=00020 chg=0 gcnt=0003 stable=0",
                         e, clean_a, chg_a, gcnt_a, stable_a);
            end
        end
        en_a = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            exp_clean = (e >= 4) ? 19'h00420 : 19'h00020;
            exp_chg   = (e == 4);
            exp_mask  = exp_chg ? 19'h00400 : 19'h0;
            vec_cnt++;
            if (clean_a !== exp_clean || chg_a !== exp_chg || mask_a !== exp_mask || gcnt_a !== 16'd3) begin
                err_cnt++;
                $display("FAIL reenable edge %0d: clean=%h chg=%b mask=%h gcnt=%h, expected clean=%h chg=%b mask=%h gcnt=0003",
                         e, clean_a, chg_a, mask_a, gcnt_a, exp_clean, exp_chg, exp_mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        raw_a = 19'h01420;
        step(5);
        reset_a = 1'b1;
        step(1);
        vec_cnt++;
        if (clean_a !== 19'h0 || chg_a !== 1'b0 || mask_a !== 19'h0 || gcnt_a !== 16'h0) begin
            err_cnt++;
            $display("FAIL reset_mid: clean=%h chg=%b mask=%h gcnt=%h, expected all zero",
                     clean_a, chg_a, mask_a, gcnt_a);
        end
        raw_a = '0;
        step(1);
        reset_a = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            vec_cnt++;
            if (clean_a !== 19'h0 || chg_a !== 1'b0 || gcnt_a !== 16'h0) begin
                err_cnt++;
                $display("FAIL reset_mid_after edge %0d: clean=%h chg=%b gcnt=%h, expected 0/0/0",
                         e, clean_a, chg_a, gcnt_a);
            end
        end
    endtask

    // Ticks fall on edges 4,8,12,... after release; sync_q changes at edge
    // 12, so the 2nd following tick (edge 20) accepts: step edge 10.
    task automatic test_prescaler();
        logic [W-1:0] exp_clean, exp_mask;
        logic         exp_chg;
        reset_b = 1'b1; en_b = 1'b1; raw_b = '0;
        step(2);
        reset_b = 1'b0;
        step(10);
        raw_b = 19'h00008;
        for (int e = 1; e <= 11; e++) begin
            step(1);
            exp_clean = (e >= 10) ? 19'h00008 : 19'h0;
            exp_chg   = (e == 10);
            exp_mask  = exp_chg ? 19'h00008 : 19'h0;
            vec_cnt++;
            if (clean_b !== exp_clean || chg_b !== exp_chg || mask_b !== exp_mask || gcnt_b !== 16'h0) begin
                err_cnt++;
                $display("FAIL prescaler edge %0d: clean=%h chg=%b mask=%h gcnt=%h, expected clean=%h chg=%b mask=%h gcnt=0",
                         e, clean_b, chg_b, mask_b, gcnt_b, exp_clean, exp_chg, exp_mask);
            end
        end
    endtask

    // Bits 0 and 1 toggle in opposite phase, so one of them glitches on
    // nearly every edge.
    task automatic test_saturation();
        reset_a = 1'b1; raw_a = '0; en_a = 1'b1;
        step(2);
        reset_a = 1'b0;
        step(3);
        for (int i = 0; i < 65600; i++) begin
            raw_a = (i % 2 == 0) ? 19'h00001 : 19'h00002;
            step(1);
        end
        vec_cnt++;
        if (gcnt_a !== 16'hFFFF || clean_a !== 19'h0) begin
            err_cnt++;
            $display("FAIL saturate: gcnt=%h clean=%h, expected gcnt=ffff clean=0", gcnt_a, clean_a);
        end
        for (int i = 0; i < 200; i++) begin
            raw_a = (i % 2 == 0) ? 19'h00001 : 19'h00002;
            step(1);
        end
        vec_cnt++;
        if (gcnt_a !== 16'hFFFF || clean_a !== 19'h0) begin
            err_cnt++;
            $display("FAIL saturate_hold: gcnt=%h clean=%h, expected gcnt=ffff clean=0", gcnt_a, clean_a);
        end
    endtask

    initial begin
        reset_a = 1'b1; en_a = 1'b1; raw_a = '0;
        reset_b = 1'b1; en_b = 1'b0; raw_b = '0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_enable_mid();
        test_reset_mid();
        test_prescaler();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
